// File: rtl/mem_pkg.sv
// Shared load/store encodings and memory-map constants for the data memory responder.
// Latency: none (constants only).
// Backpressure: none (constants only).
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] MMIO_CYCLE_LO = 32'h0000_0000;
    localparam logic [31:0] MMIO_CYCLE_HI = 32'h0000_0004;
    localparam logic [31:0] MMIO_TOHOST   = 32'h0000_0008;

    localparam int          DEPTH_WORDS_DEF = 256;
    localparam logic [31:0] MMIO_BASE_DEF   = 32'h1000_0000;
endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables and replicated write data, load extraction and extension.
// Latency: purely combinational.
// Backpressure: none; evaluates every cycle.
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] writedata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be         = 4'b0000;
        wdata_lane = writedata;
        rdata_ext  = 32'h0;
        misaligned = 1'b0;
        byte_sel   = rdata_raw[{addr_lo, 3'b000} +: 8];
        half_sel   = rdata_raw[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            F3_B, F3_BU: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{writedata[7:0]}};
                rdata_ext  = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                              : {24'h0, byte_sel};
            end
            F3_H, F3_HU: begin
                misaligned = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{writedata[15:0]}};
                rdata_ext  = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                              : {16'h0, half_sel};
            end
            F3_W: begin
                misaligned = |addr_lo;
                be         = 4'b1111;
                rdata_ext  = rdata_raw;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory for the single-cycle core: word RAM with byte lanes, cycle counter and tohost MMIO.
// Latency: loads return combinationally; stores, counter and tohost update at the rising edge.
// Backpressure: none; every access completes in its own cycle or is flagged and dropped.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    input  logic [2:0]  funct3,
    input  logic        memwrite,
    input  logic        memread,
    output logic [31:0] readdata,
    output logic        misaligned,
    output logic        access_fault,
    output logic        done,
    output logic [31:0] tohost_val
);
    localparam int          IDXW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0] ram [DEPTH_WORDS];
    logic [63:0] cycle_cnt;

    logic [IDXW-1:0] ram_idx;
    logic [31:0]     waddr, rdata_raw, mmio_val, wdata_lane, rdata_ext;
    logic [3:0]      be;
    logic            lane_mis, access, is_store, is_load;
    logic            in_ram, hit_lo, hit_hi, hit_tohost, in_mmio;
    logic            f3_bad, ok;

    assign access   = memread | memwrite;
    assign is_store = memwrite;
    assign is_load  = memread & ~memwrite;

    assign waddr      = {addr[31:2], 2'b00};
    assign in_ram     = addr < RAM_BYTES;
    assign ram_idx    = addr[IDXW+1:2];
    assign hit_lo     = waddr == (MMIO_BASE + MMIO_CYCLE_LO);
    assign hit_hi     = waddr == (MMIO_BASE + MMIO_CYCLE_HI);
    assign hit_tohost = waddr == (MMIO_BASE + MMIO_TOHOST);
    assign in_mmio    = hit_lo | hit_hi | hit_tohost;

    always_comb begin
        if (is_store)
            f3_bad = !(funct3 inside {F3_B, F3_H, F3_W});
        else
            f3_bad = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end

    assign mmio_val  = hit_lo ? cycle_cnt[31:0] : (hit_hi ? cycle_cnt[63:32] : 32'h0);
    assign rdata_raw = in_ram ? ram[ram_idx] : mmio_val;

    lsu_lane_align u_align (
        .funct3     (funct3),
        .addr_lo    (addr[1:0]),
        .writedata  (writedata),
        .rdata_raw  (rdata_raw),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .misaligned (lane_mis)
    );

    // MMIO is word-only; tohost is write-only so reading it is a fault.
    assign misaligned   = access & lane_mis;
    assign access_fault = access & (f3_bad | ~(in_ram | in_mmio)
                                   | (in_mmio & (funct3 != F3_W))
                                   | (is_load & hit_tohost));
    assign ok           = access & ~misaligned & ~access_fault;
    assign readdata     = (is_load & ok) ? rdata_ext : 32'h0;

    always_ff @(posedge clk) begin
        if (!reset && is_store && ok && in_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    ram[ram_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt  <= 64'h0;
            done       <= 1'b0;
            tohost_val <= 32'h0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'h1;
            if (is_store && ok && hit_tohost && !done) begin
                done       <= 1'b1;
                tohost_val <= writedata;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a byte-array reference model checked every cycle.
module tb_data_mem_responder;
    localparam int          DW   = 256;
    localparam logic [31:0] MB   = 32'h1000_0000;
    localparam logic [2:0]  LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0, writedata = '0;
    logic [2:0]  funct3 = '0;
    logic        memwrite = 1'b0, memread = 1'b0;
    logic [31:0] readdata, tohost_val;
    logic        misaligned, access_fault, done;

    int total = 0;
    int bad = 0;

    data_mem_responder #(.DEPTH_WORDS(DW), .MMIO_BASE(MB)) dut (
        .clk(clk), .reset(reset), .addr(addr), .writedata(writedata), .funct3(funct3),
        .memwrite(memwrite), .memread(memread), .readdata(readdata), .misaligned(misaligned),
        .access_fault(access_fault), .done(done), .tohost_val(tohost_val)
    );

    always #5 clk = ~clk;

    // Reference state: memory as bytes with a known-bit per byte, plain counter and tohost.
    logic [7:0]  m_mem [DW*4];
    bit          m_known [DW*4];
    logic [63:0] m_cnt = '0;
    bit          m_done = 1'b0;
    logic [31:0] m_tohost = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int width_of(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    task automatic model_eval(output logic [31:0] rd, output logic mis, output logic flt,
                              output bit rd_valid);
        bit   acc, st, ld, legal, in_ram, in_mmio, sgn;
        int   sz;
        logic [31:0] w, v;
        acc = memread || memwrite;
        st  = memwrite;
        ld  = memread && !memwrite;
        sz  = width_of(funct3);
        legal = st ? (funct3 <= 3'b010) : (sz != 0);
        w = addr & ~32'h3;
        in_ram  = addr < DW * 4;
        in_mmio = (w == MB) || (w == MB + 4) || (w == MB + 8);
        mis = acc && sz > 1 && (addr % sz) != 0;
        flt = acc && (!legal || !(in_ram || in_mmio) || (in_mmio && funct3 != LW)
                      || (ld && w == MB + 8));
        rd = 32'h0;
        rd_valid = !(memread && memwrite);
        if (ld && !mis && !flt) begin
            if (in_ram) begin
                v = 32'h0;
                for (int i = 0; i < sz; i++) begin
                    v = v | (32'(m_mem[addr + i]) << (8 * i));
                    if (!m_known[addr + i]) rd_valid = 1'b0;
                end
                sgn = !funct3[2] && sz < 4 && v[8*sz-1];
                if (sgn) v = v | (32'hFFFF_FFFF << (8 * sz));
                rd = v;
            end else begin
                rd = (w == MB) ? m_cnt[31:0] : m_cnt[63:32];
            end
        end
    endtask

    always @(posedge clk) begin
        logic [31:0] rd;
        logic mis, flt;
        bit rv;
        model_eval(rd, mis, flt, rv);
        if (reset) begin
            m_cnt = '0;
            m_done = 1'b0;
            m_tohost = '0;
        end else begin
            if (memwrite && !mis && !flt) begin
                if (addr < DW * 4) begin
                    for (int i = 0; i < width_of(funct3); i++) begin
                        m_mem[addr + i] = writedata[8*i +: 8];
                        m_known[addr + i] = 1'b1;
                    end
                end else if ((addr & ~32'h3) == MB + 8 && !m_done) begin
                    m_done = 1'b1;
                    m_tohost = writedata;
                end
            end
            m_cnt = m_cnt + 64'h1;
        end
    end

    always @(negedge clk) begin
        logic [31:0] rd;
        logic mis, flt;
        bit rv;
        model_eval(rd, mis, flt, rv);
        check("cyc_misaligned", {31'h0, misaligned}, {31'h0, mis});
        check("cyc_fault", {31'h0, access_fault}, {31'h0, flt});
        check("cyc_done", {31'h0, done}, {31'h0, m_done});
        check("cyc_tohost", tohost_val, m_tohost);
        if (rv) check("cyc_readdata", readdata, rd);
    end

    task automatic op(input logic rs, input logic w, input logic r, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        reset = rs; memwrite = w; memread = r; funct3 = f; addr = a; writedata = d;
        @(negedge clk);
    endtask

    initial begin
        // Reset and cycle counter
        op(1, 0, 0, LW, 0, 0);
        op(1, 0, 0, LW, 0, 0);
        op(0, 0, 0, LW, 0, 0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_tohost", tohost_val, 32'h0);
        op(0, 0, 1, LW, MB, 0);
        check("cnt_first", readdata, 32'd1);
        op(0, 0, 1, LW, MB, 0);
        check("cnt_second", readdata, 32'd2);

        // Load widths and extension
        op(0, 1, 0, LW, 32'h10, 32'hDEAD_BEEF);
        op(0, 0, 1, LB, 32'h13, 0);
        check("lb_13", readdata, 32'hFFFF_FFDE);
        op(0, 0, 1, LBU, 32'h13, 0);
        check("lbu_13", readdata, 32'h0000_00DE);
        op(0, 0, 1, LH, 32'h12, 0);
        check("lh_12", readdata, 32'hFFFF_DEAD);
        op(0, 0, 1, LHU, 32'h10, 0);
        check("lhu_10", readdata, 32'h0000_BEEF);

        // Partial stores
        op(0, 1, 0, LB, 32'h11, 32'h0000_0055);
        op(0, 0, 1, LW, 32'h10, 0);
        check("sb_merge", readdata, 32'hDEAD_55EF);
        op(0, 1, 0, LH, 32'h12, 32'h0000_1234);
        op(0, 0, 1, LW, 32'h10, 0);
        check("sh_merge", readdata, 32'h1234_55EF);

        // Misalignment, illegal funct3, out-of-map
        op(0, 1, 0, LW, 32'h20, 32'h1122_3344);
        op(0, 1, 0, LW, 32'h22, 32'hCAFE_F00D);
        check("sw_mis_flag", {31'h0, misaligned}, 32'h1);
        op(0, 0, 1, LW, 32'h20, 0);
        check("sw_mis_nowrite", readdata, 32'h1122_3344);
        op(0, 0, 1, LH, 32'h21, 0);
        check("lh_mis_flag", {31'h0, misaligned}, 32'h1);
        check("lh_mis_zero", readdata, 32'h0);
        op(0, 1, 0, 3'b011, 32'h10, 32'hFFFF_FFFF);
        check("bad_f3_fault", {31'h0, access_fault}, 32'h1);
        op(0, 1, 0, LW, 32'h0, 32'h1357_9BDF);
        op(0, 1, 0, LW, DW * 4, 32'h7777_7777);
        check("oob_fault", {31'h0, access_fault}, 32'h1);
        op(0, 0, 1, LW, 32'h0, 0);
        check("oob_nowrite", readdata, 32'h1357_9BDF);
        op(0, 0, 1, LW, 32'h10, 0);
        check("bad_f3_nowrite", readdata, 32'h1234_55EF);

        // tohost
        op(0, 1, 0, LW, MB + 8, 32'h1);
        op(0, 0, 0, LW, 0, 0);
        check("tohost_done", {31'h0, done}, 32'h1);
        check("tohost_val1", tohost_val, 32'h1);
        op(0, 1, 0, LW, MB + 8, 32'h2);
        op(0, 0, 1, LW, MB + 8, 0);
        check("tohost_sticky", tohost_val, 32'h1);
        check("tohost_rd_fault", {31'h0, access_fault}, 32'h1);
        check("tohost_rd_zero", readdata, 32'h0);
        op(1, 0, 0, LW, 0, 0);
        op(1, 1, 0, LW, MB + 8, 32'h3);
        op(0, 0, 0, LW, 0, 0);
        check("tohost_rst_wins", {31'h0, done}, 32'h0);
        check("tohost_rst_val", tohost_val, 32'h0);

        // Counter wrap via deposit
        @(posedge clk);
        #2;
        dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        reset = 0; memwrite = 0; memread = 1; funct3 = LW; addr = MB + 4; writedata = 0;
        @(negedge clk);
        check("cnt_hi_max", readdata, 32'hFFFF_FFFF);
        op(0, 0, 1, LW, MB, 0);
        check("cnt_lo_wrap", readdata, 32'h0);
        op(0, 0, 1, LW, MB + 4, 0);
        check("cnt_hi_wrap", readdata, 32'h0);

        // memread and memwrite together act as a store
        op(0, 1, 1, LW, 32'h4, 32'hA5A5_A5A5);
        op(0, 0, 1, LW, 32'h4, 0);
        check("rw_as_store", readdata, 32'hA5A5_A5A5);
        op(0, 0, 0, LW, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the single-cycle core's load/store port.
- Consumes the core's address, store data, funct3 and memwrite; returns readdata within the same cycle.
- Holds word-organised data RAM with byte/halfword lanes, plus a small MMIO region: a free-running 64-bit cycle counter and a write-once tohost register for test termination.
- Flags misaligned and out-of-map accesses.

Parameters:
DEPTH_WORDS, 256, number of 32-bit RAM words; RAM occupies 0x0000_0000 .. DEPTH_WORDS*4-1
MMIO_BASE, 32'h1000_0000, base of MMIO page: +0x0 cycle_lo (RO), +0x4 cycle_hi (RO), +0x8 tohost (WO)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
addr  in  32  byte address (core ALU result)
writedata  in  32  store data (core rd2)
funct3  in  3  load/store width/sign code from instruction
memwrite  in  1  store strobe from control unit
memread  in  1  load strobe (decoded from resultsrc)
readdata  out  32  load result, sign/zero-extended, combinational
misaligned  out  1  combinational, current access misaligned
access_fault  out  1  combinational, unmapped address, illegal funct3, or load from tohost
done  out  1  registered, set by first tohost write
tohost_val  out  32  registered, value of first tohost write

Behaviour:
- Reset (synchronous, active-high): cycle counter=0, done=0, tohost_val=0. RAM contents are not reset. Stores are suppressed in any cycle with reset=1.
- Read path (zero latency, combinational from addr/funct3/memread/RAM):
  - lb=000, lh=001, lw=010, lbu=100, lhu=101.
  - Byte/half selected by addr[1:0]/addr[1]; signed codes sign-extend, unsigned codes zero-extend.
  - readdata=0 when memread=0, misaligned, faulting, or funct3 is illegal.
- Store path: commits at the rising edge when memwrite=1, reset=0, aligned and mapped.
  - sb=000 writes lane addr[1:0]; sh=001 writes lanes {addr[1],0},{addr[1],1}; sw=010 writes all 4 lanes.
  - Stored bytes come from the low bits of writedata.
  - Other funct3 codes: no write, access_fault=1.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=0. Misaligned access sets misaligned=1 and suppresses the access (no write, readdata=0).
- Address map:
  - RAM index = addr[31:2] when addr < DEPTH_WORDS*4.
  - MMIO registers are word-only: any non-word funct3 to MMIO gives access_fault=1 and no effect.
  - Any other address with memread|memwrite gives access_fault=1.
- Flag qualification: flags are meaningful only when memread|memwrite; otherwise both are 0.
- memread and memwrite both high: treated as store. Load result is don't-care; flags reflect the store.
- Cycle counter: 64-bit, +1 every non-reset cycle, wraps 2^64-1 -> 0.
  - cycle_lo/hi readable as lw; lw at the same edge the counter increments returns the pre-increment value.
  - Stores to the counter are ignored (no fault).
- tohost:
  - First sw with done=0 sets done=1 and tohost_val=writedata at that edge.
  - Later writes are ignored until reset. Reset in the same cycle as a tohost write wins (done stays 0).
  - Loads from tohost return 0 with access_fault=1.

Decomposition:
- Shared package (mem_pkg): funct3 load/store constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), MMIO offset constants, default DEPTH_WORDS.
- One sub-module, lsu_lane_align (combinational):
  - Inputs: funct3, addr[1:0], writedata, raw read word.
  - Outputs: 4-bit byte-enable, lane-shifted write word, extended load value, misaligned flag.
- The top holds the RAM, address decode, counter and tohost registers.

Test Plan:
1. reset=1 for 2 cycles, then release: done=0, tohost_val=0; lw MMIO_BASE+0 returns 1 on the first post-reset cycle, then increments by 1 per cycle.
2. sw 0xDEADBEEF at 0x10, then lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x0000BEEF.
3. sb 0x55 at 0x11 over word 0xDEADBEEF -> lw 0x10 = 0xDEAD55EF; sh 0x1234 at 0x12 -> lw 0x10 = 0x123455EF.
4. sw at 0x22 -> misaligned=1 and the word is unchanged; lh at 0x21 -> misaligned=1, readdata=0; sw at DEPTH_WORDS*4 -> access_fault=1 and no RAM change.
5. sw 0x1 to MMIO_BASE+8 -> done=1, tohost_val=1 next cycle; a second sw of 0x2 leaves tohost_val=1; sw with reset=1 in the same cycle leaves done=0.
6. Force counter to 0xFFFFFFFF_FFFFFFFF (hierarchical deposit) -> next cycle cycle_hi=0, cycle_lo=0; memwrite=memread=1 sw 0xA5A5A5A5 to 0x4 -> lw 0x4 = 0xA5A5A5A5.
